neopix_frame_reader: RTL and testbench

NEOPIX_FRAME_READER -- requirements
Module: neopix_frame_reader

---
 rtl/neopix_pkg.sv | 24 ++
 rtl/neopix_bit_encoder.sv | 53 +++++
 rtl/neopix_frame_reader.sv | 169 ++++++++++++++++
 tb/tb_neopix_frame_reader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared state encoding, timing defaults and widths for the WS2812 frame reader.
package neopix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int DEF_T_BIT   = 62;
  localparam int DEF_T0H     = 20;
  localparam int DEF_T1H     = 40;
  localparam int DEF_T_LATCH = 3000;
  localparam int PIX_W       = 24;
  localparam int ADDR_W      = 9;
  localparam int CNT_W       = 10;

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req,
                                                   input logic [CNT_W-1:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/neopix_bit_encoder.sv
// Single WS2812 bit waveform: a go pulse starts a T_BIT-cycle bit whose high
// phase lasts T0H or T1H cycles; bit_done marks the last cycle of the bit.
module neopix_bit_encoder
  import neopix_pkg::*;
#(
  parameter int T_BIT = DEF_T_BIT,
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H
) (
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI0  = CW'(T0H);
  localparam logic [CW-1:0] HI1  = CW'(T1H);

  logic          active;
  logic          bit_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign bit_done = active && (cnt == LAST);
  assign cnt_nxt  = cnt + 1'b1;

  // go on the last cycle of a bit restarts immediately, giving gapless bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      bit_q  <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      bit_q  <= bit_val;
      cnt    <= '0;
      dout   <= 1'b1;
    end else if (bit_done) begin
      active <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else if (active) begin
      cnt    <= cnt_nxt;
      dout   <= cnt_nxt < (bit_q ? HI1 : HI0);
    end
  end

endmodule

// File: rtl/neopix_frame_reader.sv
// Streams a frame of 24-bit GRB pixels from a 2-cycle-latency buffer to a
// WS2812 chain, prefetching the next pixel while the current one shifts out.
module neopix_frame_reader
  import neopix_pkg::*;
#(
  parameter int NUM_WORDS = 512,
  parameter int T_BIT     = DEF_T_BIT,
  parameter int T0H       = DEF_T0H,
  parameter int T1H       = DEF_T1H,
  parameter int T_LATCH   = DEF_T_LATCH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  pixel_count,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [31:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              dout
);

  localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;
  localparam logic [LW-1:0]    LAT_LAST = LW'(T_LATCH - 1);
  localparam logic [CNT_W-1:0] MAX_PIX  = CNT_W'(NUM_WORDS);
  localparam logic [4:0]       TOP_BIT  = 5'(PIX_W - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   req_count;
  logic [CNT_W-1:0]   pix_left;
  logic [4:0]         bit_idx;
  logic [PIX_W-1:0]   sr;
  logic [PIX_W-1:0]   pf;
  logic [2:0]         pf_req;
  logic [LW-1:0]      lat_cnt;
  logic               lat_hold;
  logic               go;
  logic               go_bit;
  logic               shift_bit;
  logic               load_pix;
  logic               bit_done;
  logic               unused_rd;

  assign unused_rd = &{1'b0, rd_data[31:PIX_W]};
  assign req_count = clamp_count(pixel_count, MAX_PIX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    go_bit    = 1'b0;
    shift_bit = 1'b0;
    load_pix  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (req_count == '0) ? LATCH : FETCH;
      end
      FETCH: begin
        if (pf_req[2]) begin
          state_nxt = SHIFT;
          go        = 1'b1;
          go_bit    = rd_data[PIX_W-1];
        end
      end
      SHIFT: begin
        if (bit_done) begin
          if (bit_idx != '0) begin
            shift_bit = 1'b1;
            go        = 1'b1;
            go_bit    = sr[PIX_W-2];
          end else if (pix_left != CNT_W'(1)) begin
            load_pix  = 1'b1;
            go        = 1'b1;
            go_bit    = pf[PIX_W-1];
          end else begin
            state_nxt = LATCH;
          end
        end
      end
      LATCH: begin
        if (!lat_hold && (lat_cnt == LAT_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pf_req tracks the 3-edge read latency from each address update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdaddress <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_left  <= '0;
      bit_idx   <= '0;
      sr        <= '0;
      pf        <= '0;
      pf_req    <= '0;
      lat_cnt   <= '0;
      lat_hold  <= 1'b0;
    end else begin
      done   <= 1'b0;
      pf_req <= {pf_req[1:0], 1'b0};
      if (pf_req[2] && (state != FETCH)) pf <= rd_data[PIX_W-1:0];
      case (state)
        IDLE: begin
          if (start) begin
            pix_left  <= req_count;
            rdaddress <= '0;
            busy      <= 1'b1;
            lat_cnt   <= '0;
            lat_hold  <= (req_count == '0);
            pf_req    <= {2'b00, (req_count != '0)};
          end
        end
        FETCH: begin
          if (pf_req[2]) begin
            sr        <= rd_data[PIX_W-1:0];
            bit_idx   <= TOP_BIT;
            rdaddress <= rdaddress + 1'b1;
            pf_req    <= 3'b001;
          end
        end
        SHIFT: begin
          if (shift_bit) begin
            sr      <= sr << 1;
            bit_idx <= bit_idx - 1'b1;
          end else if (load_pix) begin
            sr        <= pf;
            bit_idx   <= TOP_BIT;
            pix_left  <= pix_left - 1'b1;
            rdaddress <= rdaddress + 1'b1;
            pf_req    <= 3'b001;
          end
        end
        LATCH: begin
          // an empty frame spends its acceptance cycle here before counting
          if (lat_hold) begin
            lat_hold <= 1'b0;
          end else if (lat_cnt == LAT_LAST) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  neopix_bit_encoder #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_enc (
    .clock    (clock),
    .reset_n  (reset_n),
    .go       (go),
    .bit_val  (go_bit),
    .dout     (dout),
    .bit_done (bit_done)
  );

endmodule

// File: tb/tb_neopix_frame_reader.sv
// Directed bench: one instance at default timing, one with shortened timing
// for the full 512-pixel clamp frame.
module tb_neopix_frame_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_a, start_b;
  logic [9:0]  pixel_count_a, pixel_count_b;
  logic [8:0]  rdaddress_a, rdaddress_b;
  logic [31:0] rd_data_a, rd_data_b, pipe_a, pipe_b;
  logic        busy_a, busy_b, done_a, done_b, dout_a, dout_b;
  logic [31:0] mem_a [0:511];
  logic [31:0] mem_b [0:511];
  logic [23:0] exp_px [0:511];
  logic        cur = 1'b0;
  logic        cur_dout, cur_busy, cur_done;
  logic [8:0]  cur_addr;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign cur_dout = cur ? dout_b : dout_a;
  assign cur_busy = cur ? busy_b : busy_a;
  assign cur_done = cur ? done_b : done_a;
  assign cur_addr = cur ? rdaddress_b : rdaddress_a;

  // two-cycle read latency buffer model
  always @(posedge clk) begin
    pipe_a    <= mem_a[rdaddress_a];
    rd_data_a <= pipe_a;
    pipe_b    <= mem_b[rdaddress_b];
    rd_data_b <= pipe_b;
  end

  neopix_frame_reader dut_a (
    .clock(clk), .reset_n(reset_n), .start(start_a), .pixel_count(pixel_count_a),
    .rdaddress(rdaddress_a), .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .dout(dout_a)
  );

  neopix_frame_reader #(.NUM_WORDS(512), .T_BIT(3), .T0H(1), .T1H(2), .T_LATCH(10)) dut_b (
    .clock(clk), .reset_n(reset_n), .start(start_b), .pixel_count(pixel_count_b),
    .rdaddress(rdaddress_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .dout(dout_b)
  );

  task automatic pulse_start(input logic sel, input logic [9:0] count);
    @(negedge clk);
    cur = sel;
    if (sel) begin start_b = 1'b1; pixel_count_b = count; end
    else     begin start_a = 1'b1; pixel_count_a = count; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    pixel_count_a = 10'h3FF;
    pixel_count_b = 10'h3FF;
  endtask

  // Called at the first sample after acceptance; walks the frame cycle by cycle.
  task automatic check_stream(input int n, input int tbit, input int t0h, input int t1h,
                              input int tlat, input int repulse_pix, output int done_cyc);
    int          cyc;
    int          hi;
    logic        quiet;
    logic        seen_low;
    logic        bit_bad;
    logic        v;
    logic [24:0] got;
    cyc = 0;
    total++;
    if (cur_busy !== 1'b1 || cur_addr !== 9'd0) begin
      bad++;
      $display("FAIL accept busy=%b addr=%0d want busy=1 addr=0", cur_busy, cur_addr);
    end
    quiet = 1'b1;
    repeat (3) begin
      if (cur_dout !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL fetch_quiet dout went high during fetch, want low");
    end
    for (int p = 0; p < n; p++) begin
      total++;
      if (cur_addr !== 9'((p + 1) % 512)) begin
        bad++;
        $display("FAIL prefetch_addr pixel=%0d got=%0d want=%0d", p, cur_addr, (p + 1) % 512);
      end
      if (cur && p == 1) mem_b[0] = 32'h0000_DEAD;
      got = '0;
      for (int b = 23; b >= 0; b--) begin
        hi = 0;
        seen_low = 1'b0;
        bit_bad = 1'b0;
        for (int c = 0; c < tbit; c++) begin
          if (p == repulse_pix && b == 23 && c == 0) begin
            if (cur) begin start_b = 1'b1; pixel_count_b = 10'd5; end
            else     begin start_a = 1'b1; pixel_count_a = 10'd5; end
          end
          if (p == repulse_pix && b == 23 && c == 1) begin
            start_a = 1'b0;
            start_b = 1'b0;
          end
          v = cur_dout;
          if (v === 1'b1) begin
            if (seen_low) bit_bad = 1'b1;
            hi++;
          end else if (v === 1'b0) begin
            seen_low = 1'b1;
          end else begin
            bit_bad = 1'b1;
          end
          @(negedge clk);
          cyc++;
        end
        if (!bit_bad && hi == t1h)      got[b] = 1'b1;
        else if (!bit_bad && hi == t0h) got[b] = 1'b0;
        else                            got[24] = 1'b1;
      end
      total++;
      if (got !== {1'b0, exp_px[p]}) begin
        bad++;
        $display("FAIL pixel[%0d] got=%h (bit 24 = malformed bit) want=%h", p, got, {1'b0, exp_px[p]});
      end
    end
    quiet = 1'b1;
    for (int k = 0; k < tlat; k++) begin
      if (cur_dout !== 1'b0 || cur_busy !== 1'b1 || cur_done !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL latch dout/busy/done wrong during latch, want dout=0 busy=1 done=0");
    end
    done_cyc = cyc;
    total++;
    if (cur_done !== 1'b1 || cur_busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse done=%b busy=%b want done=1 busy=0 at cycle %0d", cur_done, cur_busy, cyc);
    end
    @(negedge clk);
    total++;
    if (cur_done !== 1'b0 || cur_busy !== 1'b0) begin
      bad++;
      $display("FAIL done_single done=%b busy=%b want done=0 busy=0", cur_done, cur_busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    pixel_count_a = '0;
    pixel_count_b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({dout_a, busy_a, done_a, rdaddress_a} !== 12'd0) begin
      bad++;
      $display("FAIL reset_a got=%h want=000", {dout_a, busy_a, done_a, rdaddress_a});
    end
    total++;
    if ({dout_b, busy_b, done_b, rdaddress_b} !== 12'd0) begin
      bad++;
      $display("FAIL reset_b got=%h want=000", {dout_b, busy_b, done_b, rdaddress_b});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    int dc;
    mem_a[0] = 32'h0080_0001;
    exp_px[0] = 24'h80_0001;
    pulse_start(1'b0, 10'd1);
    check_stream(1, 62, 20, 40, 3000, -1, dc);
    total++;
    if (dc !== 4491) begin
      bad++;
      $display("FAIL single_latency got=%0d want=4491", dc);
    end
  endtask

  task automatic test_three;
    int dc;
    mem_a[0] = 32'h00FF_FFFF; exp_px[0] = 24'hFF_FFFF;
    mem_a[1] = 32'h0000_0000; exp_px[1] = 24'h00_0000;
    mem_a[2] = 32'h00AA_AAAA; exp_px[2] = 24'hAA_AAAA;
    pulse_start(1'b0, 10'd3);
    check_stream(3, 62, 20, 40, 3000, -1, dc);
    total++;
    if (dc !== 7467) begin
      bad++;
      $display("FAIL three_latency got=%0d want=7467", dc);
    end
  endtask

  task automatic test_zero;
    logic quiet;
    pulse_start(1'b0, 10'd0);
    quiet = 1'b1;
    for (int k = 0; k <= 3000; k++) begin
      if (busy_a !== 1'b1 || dout_a !== 1'b0 || done_a !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL zero_latch busy/dout/done wrong in 3001-cycle window, want busy=1 dout=0 done=0");
    end
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL zero_done done=%b busy=%b want done=1 busy=0", done_a, busy_a);
    end
    @(negedge clk);
    total++;
    if (done_a !== 1'b0) begin
      bad++;
      $display("FAIL zero_done_single done=%b want 0", done_a);
    end
  endtask

  task automatic test_random;
    int dc;
    for (int i = 0; i < 2; i++) begin
      mem_a[i] = $urandom;
      exp_px[i] = mem_a[i][23:0];
    end
    pulse_start(1'b0, 10'd2);
    check_stream(2, 62, 20, 40, 3000, -1, dc);
    total++;
    if (dc !== 5979) begin
      bad++;
      $display("FAIL random_latency got=%0d want=5979", dc);
    end
  endtask

  task automatic test_midframe_reset;
    logic quiet;
    int   dc;
    for (int i = 0; i < 8; i++) mem_a[i] = {8'h77, 24'(i * 24'h111111)};
    pulse_start(1'b0, 10'd8);
    repeat (3 + 5 * 24 * 62) @(negedge clk);
    total++;
    if (dout_a !== 1'b1 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset dout=%b busy=%b want dout=1 busy=1 at pixel 5 start", dout_a, busy_a);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({dout_a, busy_a, done_a, rdaddress_a} !== 12'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=000", {dout_a, busy_a, done_a, rdaddress_a});
    end
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done_a !== 1'b0 || dout_a !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold done/dout high while in reset, want low");
    end
    reset_n = 1'b1;
    mem_a[0] = 32'h005A_0F3C; exp_px[0] = 24'h5A_0F3C;
    mem_a[1] = 32'h00F0_C381; exp_px[1] = 24'hF0_C381;
    pulse_start(1'b0, 10'd2);
    check_stream(2, 62, 20, 40, 3000, -1, dc);
    total++;
    if (dc !== 5979) begin
      bad++;
      $display("FAIL restart_latency got=%0d want=5979", dc);
    end
  endtask

  task automatic test_clamp;
    int         dc;
    logic [8:0] a;
    for (int i = 0; i < 512; i++) begin
      a = 9'(i);
      exp_px[i] = {a[7:0], ~a[7:0], {7'd0, a[8]} ^ 8'hA5};
      mem_b[i] = {8'h5C, exp_px[i]};
    end
    pulse_start(1'b1, 10'd600);
    check_stream(512, 3, 1, 2, 10, 100, dc);
    total++;
    if (dc !== 36877) begin
      bad++;
      $display("FAIL clamp_latency got=%0d want=36877", dc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_zero();
    test_random();
    test_midframe_reset();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
